truth_table_sequencer: RTL and testbench

TRUTH_TABLE_SEQUENCER -- requirements
Module: truth_table_sequencer

---
 rtl/truth_table_sequencer.sv | 112 +++++++++++
 tb/tb_truth_table_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sequencer.sv
// Self-test sequencer for a pair of 2-input gate blocks: walks {in1,in0} through
// 00..11, waits SETTLE cycles per vector, and records which vectors produced wrong results.
module truth_table_sequencer #(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       in0,
  output logic       in1,
  input  logic       and_out,
  input  logic       nand_out,
  input  logic       or_out,
  input  logic       nor_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_mask,
  output logic [1:0] first_fail
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DRIVE  = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_SAMPLE = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  logic [2:0] state;
  logic [1:0] idx;
  logic [3:0] cnt;

  logic exp_and;
  logic exp_nand;
  logic exp_or;
  logic exp_nor;
  logic vector_fail;

  assign exp_and  = in1 & in0;
  assign exp_nand = ~(in1 & in0);
  assign exp_or   = in1 | in0;
  assign exp_nor  = ~(in1 | in0);

  // Case equality so that an X or Z from the gate under test is reported as a failure.
  assign vector_fail = !((and_out === exp_and) && (nand_out === exp_nand) &&
                         (or_out === exp_or) && (nor_out === exp_nor));

  assign busy = (state == ST_DRIVE) || (state == ST_SETTLE) || (state == ST_SAMPLE);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      idx        <= 2'd0;
      cnt        <= 4'd0;
      in0        <= 1'b0;
      in1        <= 1'b0;
      pass       <= 1'b0;
      err_count  <= 3'd0;
      fail_mask  <= 4'd0;
      first_fail <= 2'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_DRIVE;
            idx        <= 2'd0;
            pass       <= 1'b0;
            err_count  <= 3'd0;
            fail_mask  <= 4'd0;
            first_fail <= 2'd0;
          end
        end
        ST_DRIVE: begin
          {in1, in0} <= idx;
          cnt        <= 4'd0;
          state      <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            state <= ST_SAMPLE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_SAMPLE: begin
          if (vector_fail) begin
            fail_mask[idx] <= 1'b1;
            err_count      <= err_count + 3'd1;
            if (fail_mask == 4'd0) begin
              first_fail <= idx;
            end
          end
          if (idx == 2'd3) begin
            state <= ST_DONE;
          end else begin
            idx   <= idx + 2'd1;
            state <= ST_DRIVE;
          end
        end
        ST_DONE: begin
          pass  <= (err_count == 3'd0);
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench: one SETTLE=2 sequencer with selectable gate faults, plus two SETTLE=1
// sequencers fed by one- and two-cycle-delayed gate models.
module tb_truth_table_sequencer;

  logic clk;
  logic rst;
  logic start;
  int   fault;
  int   checks;
  int   failures;

  logic       in0, in1, and_out, nand_out, or_out, nor_out;
  logic       busy, done, pass;
  logic [2:0] err_count;
  logic [3:0] fail_mask;
  logic [1:0] first_fail;

  logic       d1_in0, d1_in1, d1_busy, d1_done, d1_pass;
  logic [2:0] d1_err;
  logic [3:0] d1_mask, d1_g;
  logic [1:0] d1_ff;

  logic       d2_in0, d2_in1, d2_busy, d2_done, d2_pass;
  logic [2:0] d2_err;
  logic [3:0] d2_mask, d2_ga, d2_gb;
  logic [1:0] d2_ff;

  truth_table_sequencer #(.SETTLE(2)) dut (
    .clk(clk), .rst(rst), .start(start), .in0(in0), .in1(in1),
    .and_out(and_out), .nand_out(nand_out), .or_out(or_out), .nor_out(nor_out),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_mask(fail_mask), .first_fail(first_fail)
  );

  truth_table_sequencer #(.SETTLE(1)) dut_d1 (
    .clk(clk), .rst(rst), .start(start), .in0(d1_in0), .in1(d1_in1),
    .and_out(d1_g[3]), .nand_out(d1_g[2]), .or_out(d1_g[1]), .nor_out(d1_g[0]),
    .busy(d1_busy), .done(d1_done), .pass(d1_pass), .err_count(d1_err),
    .fail_mask(d1_mask), .first_fail(d1_ff)
  );

  truth_table_sequencer #(.SETTLE(1)) dut_d2 (
    .clk(clk), .rst(rst), .start(start), .in0(d2_in0), .in1(d2_in1),
    .and_out(d2_gb[3]), .nand_out(d2_gb[2]), .or_out(d2_gb[1]), .nor_out(d2_gb[0]),
    .busy(d2_busy), .done(d2_done), .pass(d2_pass), .err_count(d2_err),
    .fail_mask(d2_mask), .first_fail(d2_ff)
  );

  // fault 1: and_out stuck at 0; fault 2: nor_out inverted
  assign and_out  = (fault == 1) ? 1'b0 : (in1 & in0);
  assign nand_out = ~(in1 & in0);
  assign or_out   = in1 | in0;
  assign nor_out  = (fault == 2) ? (in1 | in0) : ~(in1 | in0);

  always_ff @(posedge clk) begin
    d1_g  <= {d1_in1 & d1_in0, ~(d1_in1 & d1_in0), d1_in1 | d1_in0, ~(d1_in1 | d1_in0)};
    d2_ga <= {d2_in1 & d2_in0, ~(d2_in1 & d2_in0), d2_in1 | d2_in0, ~(d2_in1 | d2_in0)};
    d2_gb <= d2_ga;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in"}, {in1, in0}, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_err"}, err_count, 0);
    chk({tag, "_mask"}, fail_mask, 0);
    chk({tag, "_ff"}, first_fail, 0);
  endtask

  // Start a run at edge 0 and watch edges 1..30; optional stray start pulses at 3, 7, 16.
  task automatic do_run(input bit extra, output int done_edge, output int done_cnt,
                        output int d1_done_edge);
    done_edge = -1;
    done_cnt = 0;
    d1_done_edge = -1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("clr_err", err_count, 0);
    chk("clr_mask", fail_mask, 0);
    chk("clr_pass", pass, 0);
    chk("busy_e0", busy, 1);
    for (int e = 1; e <= 30; e++) begin
      start = extra && (e == 3 || e == 7 || e == 16);
      @(posedge clk);
      #1;
      if (done) begin
        done_cnt++;
        if (done_edge < 0) done_edge = e;
      end
      if (d1_done && d1_done_edge < 0) d1_done_edge = e;
      if (e <= 16) chk($sformatf("vec_e%0d", e), {in1, in0}, (e - 1) / 4);
      if (e == 15) chk("busy_e15", busy, 1);
      if (e == 16) chk("busy_e16", busy, 0);
    end
    start = 1'b0;
  endtask

  typedef struct {
    int fault;
    int exp_err;
    int exp_mask;
    int exp_ff;
    int exp_pass;
  } vec_t;

  vec_t tbl[3];
  int   de, dc, d1e;

  initial begin
    tbl[0] = '{fault: 0, exp_err: 0, exp_mask: 4'b0000, exp_ff: 0, exp_pass: 1};
    tbl[1] = '{fault: 1, exp_err: 1, exp_mask: 4'b1000, exp_ff: 3, exp_pass: 0};
    tbl[2] = '{fault: 2, exp_err: 4, exp_mask: 4'b1111, exp_ff: 0, exp_pass: 0};
    checks = 0;
    failures = 0;
    fault = 0;
    start = 1'b0;
    rst = 1'b1;
    #12;
    chk_all_zero("rst");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 3; i++) begin
      fault = tbl[i].fault;
      do_run(1'b0, de, dc, d1e);
      chk("done_edge", de, 16);
      chk("done_cnt", dc, 1);
      chk("err_count", err_count, tbl[i].exp_err);
      chk("fail_mask", fail_mask, tbl[i].exp_mask);
      chk("first_fail", first_fail, tbl[i].exp_ff);
      chk("pass", pass, tbl[i].exp_pass);
      chk("in_hold", {in1, in0}, 3);
      chk("d1_done_edge", d1e, 12);
      chk("d1_pass", d1_pass, 1);
      chk("d2_pass", d2_pass, 0);
      $display("run fault=%0d done_edge=%0d err=%0d mask=%b first=%0d pass=%0b",
               fault, de, err_count, fail_mask, first_fail, pass);
    end

    fault = 0;
    do_run(1'b1, de, dc, d1e);
    chk("extra_done_edge", de, 16);
    chk("extra_done_cnt", dc, 1);
    chk("extra_pass", pass, 1);
    $display("run stray_starts done_edge=%0d done_cnt=%0d pass=%0b", de, dc, pass);

    // Reset mid-run, held across an edge with start asserted.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    start = 1'b1;
    #1;
    chk_all_zero("midrst");
    @(posedge clk);
    #1;
    chk("rst_start_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    dc = 0;
    for (int e = 0; e < 25; e++) begin
      @(posedge clk);
      #1;
      if (done) dc++;
    end
    chk("abort_no_done", dc, 0);
    $display("run reset_abort done_cnt=%0d", dc);

    do_run(1'b0, de, dc, d1e);
    chk("post_rst_done_edge", de, 16);
    chk("post_rst_pass", pass, 1);
    chk("post_rst_err", err_count, 0);
    $display("run post_reset done_edge=%0d pass=%0b err=%0d", de, pass, err_count);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
